pattern_detector_gen: RTL and testbench

Streaming symbol-pattern detector, the parametrised successor of the fixed 4-character detector.
- Compares a sliding window of the last PAT_LEN accepted symbols against a runtime-loadable pattern.
- Reports each hit on a 4-phase found/ack handshake, with a one-deep pending slot, a saturating hit counter and a sticky overflow flag.
- Sits between the character stream source and the host-side controller.

---
 rtl/pattern_detector_gen_pkg.sv | 18 +
 rtl/pattern_detector_gen_if.sv | 29 ++
 rtl/pattern_detector_gen_window.sv | 64 ++++++
 rtl/pattern_detector_gen.sv | 105 ++++++++++
 tb/tb_pattern_detector_gen.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_detector_gen_pkg.sv
// Shared types and character constants for the streaming pattern detector.
// Optional feature macro: PATTERN_DETECTOR_OVERLAP_EN (see pd_window).
package pattern_detector_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FOUND    = 2'd1,
    ACK_WAIT = 2'd2
  } state_e;

  localparam logic [7:0] CH_A = 8'h61;
  localparam logic [7:0] CH_B = 8'h62;
  localparam logic [7:0] CH_O = 8'h6F;

  // "boab", first symbol in the MSBs
  localparam logic [31:0] DEFAULT_PATTERN = {CH_B, CH_O, CH_A, CH_B};

endpackage

// File: rtl/pattern_detector_gen_if.sv
// Stream, pattern-load and found/ack handshake bundle of the pattern detector.
// master = stream source / host side, slave = detector.
interface pattern_detector_gen_if #(
  parameter int SYM_W   = 8,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) ();

  logic                     in_valid;
  logic [SYM_W-1:0]         in_data;
  logic                     pat_load;
  logic [PAT_LEN*SYM_W-1:0] pat_in;
  logic                     ack;
  logic                     ovf_clr;
  logic                     found;
  logic [CNT_W-1:0]         match_cnt;
  logic                     overflow;

  modport master (
    output in_valid, in_data, pat_load, pat_in, ack, ovf_clr,
    input  found, match_cnt, overflow
  );

  modport slave (
    input  in_valid, in_data, pat_load, pat_in, ack, ovf_clr,
    output found, match_cnt, overflow
  );

endinterface

// File: rtl/pattern_detector_gen_window.sv
// pd_window: sliding symbol window, fill counter, pattern register and the
// combinational hit comparator.
// Macro PATTERN_DETECTOR_OVERLAP_EN: when defined a hit leaves the window
// and fill untouched (overlapping hits); otherwise a hit restarts matching.
module pd_window
  import pattern_detector_pkg::*;
#(
  parameter int                       SYM_W   = 8,
  parameter int                       PAT_LEN = 4,
  parameter logic [PAT_LEN*SYM_W-1:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [SYM_W-1:0]         in_data,
  input  logic                     pat_load,
  input  logic [PAT_LEN*SYM_W-1:0] pat_in,
  output logic                     hit
);

  localparam int WIN_W  = (PAT_LEN-1)*SYM_W;
  localparam int FILL_W = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN-1);

  logic [WIN_W-1:0]         win;
  logic [FILL_W-1:0]        fill;
  logic [PAT_LEN*SYM_W-1:0] pat;
  logic [PAT_LEN*SYM_W-1:0] cand;
  logic                     accept;

  // A symbol arriving alongside pat_load is discarded.
  assign accept = in_valid && !pat_load;
  assign cand   = {win, in_data};
  assign hit    = accept && (fill == FILL_FULL) && (cand == pat);

  // Pattern register, runtime loadable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      pat <= PATTERN;
    else if (pat_load) pat <= pat_in;
  end

  // Window shift: oldest symbol falls out of the MSBs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    win <= '0;
    else if (accept) win <= cand[WIN_W-1:0];
  end

  // Fill count of valid symbols in the window, saturating at PAT_LEN-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill <= '0;
    end else if (pat_load) begin
      fill <= '0;
    end else if (accept) begin
`ifdef PATTERN_DETECTOR_OVERLAP_EN
      if (fill != FILL_FULL) fill <= fill + 1'b1;
`else
      if (hit)                    fill <= '0;
      else if (fill != FILL_FULL) fill <= fill + 1'b1;
`endif
    end
  end

endmodule

// File: rtl/pattern_detector_gen.sv
// pattern_detector_gen: top of the streaming pattern detector. Holds the
// found/ack handshake FSM, the one-deep pending slot, the saturating hit
// counter and the sticky overflow flag; pd_window supplies the hit strobe.
// Optional feature macro: PATTERN_DETECTOR_OVERLAP_EN (handled in pd_window).
//
//   state    | meaning
//   ---------+------------------------------------------------
//   IDLE     | nothing to report, found = 0, ack ignored
//   FOUND    | found = 1, waiting for ack to rise
//   ACK_WAIT | found = 0, waiting for ack to fall
module pattern_detector_gen
  import pattern_detector_pkg::*;
#(
  parameter int                       SYM_W   = 8,
  parameter int                       PAT_LEN = 4,
  parameter logic [PAT_LEN*SYM_W-1:0] PATTERN = DEFAULT_PATTERN,
  parameter int                       CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pattern_detector_gen_if.slave  bus
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_FOUND    = FOUND;
  localparam logic [1:0] S_ACK_WAIT = ACK_WAIT;

  logic             hit;
  logic [1:0]       state, state_nxt;
  logic             pending, pending_nxt;
  logic             ovf_set;
  logic             busy, ack_release, consume;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  pd_window #(
    .SYM_W   (SYM_W),
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_window (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (bus.in_valid),
    .in_data  (bus.in_data),
    .pat_load (bus.pat_load),
    .pat_in   (bus.pat_in),
    .hit      (hit)
  );

  assign busy        = (state != S_IDLE);
  assign ack_release = (state == S_ACK_WAIT) && !bus.ack;
  assign consume     = ack_release && pending;

  // Next-state: a hit arriving as ack falls with nothing pending is shown
  // directly rather than parked, so it cannot be stranded in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (hit) state_nxt = S_FOUND;
      S_FOUND:    if (bus.ack) state_nxt = S_ACK_WAIT;
      S_ACK_WAIT: if (!bus.ack) state_nxt = (pending || hit) ? S_FOUND : S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Pending slot and overflow detection for hits while a report is in flight.
  always_comb begin
    pending_nxt = pending;
    ovf_set     = 1'b0;
    if (consume) pending_nxt = 1'b0;
    if (hit && busy && !(ack_release && !pending)) begin
      if (pending_nxt) ovf_set     = 1'b1;
      else             pending_nxt = 1'b1;
    end
  end

  // Handshake state and pending slot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  // Hit counter, saturating; dropped hits still count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (hit && (cnt != '1)) cnt <= cnt + 1'b1;
  end

  // Sticky overflow; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         ovf <= 1'b0;
    else if (ovf_set)     ovf <= 1'b1;
    else if (bus.ovf_clr) ovf <= 1'b0;
  end

  assign bus.found     = (state == S_FOUND);
  assign bus.match_cnt = cnt;
  assign bus.overflow  = ovf;

endmodule

// File: tb/tb_pattern_detector_gen.sv
// Directed + randomized bench for pattern_detector_gen. Hit counting is
// checked against a queue-based history of accepted symbols.
module tb_pattern_detector_gen;
  import pattern_detector_pkg::*;

`ifdef PATTERN_DETECTOR_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  localparam logic [7:0] CH_C = 8'h63;
  localparam logic [7:0] CH_D = 8'h64;
  localparam logic [7:0] CH_X = 8'h78;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pattern_detector_gen_if #(.SYM_W(8), .PAT_LEN(4), .CNT_W(8)) bus ();

  pattern_detector_gen #(.SYM_W(8), .PAT_LEN(4), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // reference model: accepted-symbol history since the last restart
  logic [7:0]  hist[$];
  logic [31:0] m_pat;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    hist.delete();
    m_pat = DEFAULT_PATTERN;
    m_cnt = 0;
  endfunction

  function automatic void m_load(input logic [31:0] p);
    m_pat = p;
    hist.delete();
  endfunction

  function automatic void m_accept(input logic [7:0] d);
    hist.push_back(d);
    if (hist.size() > 4) void'(hist.pop_front());
    if (hist.size() == 4 && {hist[0], hist[1], hist[2], hist[3]} == m_pat) begin
      if (m_cnt < 255) m_cnt++;
      if (!OVL) hist.delete();
    end
  endfunction

  task automatic sym(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    m_accept(d);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic sym_str(input string s);
    for (int i = 0; i < s.len(); i++) sym(s[i]);
  endtask

  // full 4-phase ack; returns found after ack has dropped again
  task automatic ack_cycle(input string tag, output logic f);
    bus.ack = 1'b1;
    tick();
    chk({tag, "_ack_hi"}, bus.found, 1'b0);
    bus.ack = 1'b0;
    tick();
    f = bus.found;
  endtask

  logic       f;
  int         base;
  logic [7:0] rsym;

  initial begin
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.pat_load = 1'b0;
    bus.pat_in   = '0;
    bus.ack      = 1'b0;
    bus.ovf_clr  = 1'b0;
    m_reset();
    #12;
    chk("rst_found", bus.found, 1'b0);
    chk("rst_cnt", bus.match_cnt, 8'd0);
    chk("rst_ovf", bus.overflow, 1'b0);
    reset_n = 1'b1;
    tick();

    // 1: single hit and handshake
    sym(CH_B); sym(CH_O); sym(CH_A);
    chk("t1_pre", bus.found, 1'b0);
    sym(CH_B);
    chk("t1_found", bus.found, 1'b1);
    chk("t1_cnt", bus.match_cnt, 8'd1);
    bus.ack = 1'b1;
    tick();
    chk("t1_ack", bus.found, 1'b0);
    tick();
    chk("t1_ack_hold", bus.found, 1'b0);
    bus.ack = 1'b0;
    tick();
    chk("t1_idle", bus.found, 1'b0);

    // 2: overlap behaviour with ack low
    base = m_cnt;
    sym_str("boaboab");
    chk("t2_found", bus.found, 1'b1);
    chk("t2_cnt", bus.match_cnt, 32'(base + (OVL ? 2 : 1)));
    chk("t2_cnt_m", bus.match_cnt, 32'(m_cnt));
    ack_cycle("t2a", f);
    chk("t2_pending", f, OVL);
    ack_cycle("t2b", f);
    chk("t2_done", f, 1'b0);

    // 3: three hits without ack -> overflow
    base = m_cnt;
    if (OVL) sym_str("boaboaboab");
    else     sym_str("boabboabboab");
    chk("t3_cnt", bus.match_cnt, 32'(base + 3));
    chk("t3_ovf", bus.overflow, 1'b1);
    ack_cycle("t3a", f);
    chk("t3_second", f, 1'b1);
    ack_cycle("t3b", f);
    chk("t3_no_third", f, 1'b0);
    chk("t3_ovf_sticky", bus.overflow, 1'b1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("t3_ovf_clr", bus.overflow, 1'b0);

    // 4: pattern load discards the coincident symbol
    base = m_cnt;
    bus.pat_load = 1'b1;
    bus.pat_in   = 32'h61626364;
    bus.in_valid = 1'b1;
    bus.in_data  = CH_A;
    m_load(32'h61626364);
    tick();
    bus.pat_load = 1'b0;
    bus.in_valid = 1'b0;
    sym(8'h62); sym(CH_C); sym(CH_D);
    chk("t4_discard", bus.found, 1'b0);
    chk("t4_discard_cnt", bus.match_cnt, 32'(base));
    sym_str("abcd");
    chk("t4_hit", bus.found, 1'b1);
    chk("t4_cnt", bus.match_cnt, 32'(base + 1));
    ack_cycle("t4", f);
    chk("t4_idle", f, 1'b0);
    sym_str("boab");
    chk("t4_old_pat", bus.found, 1'b0);
    chk("t4_old_cnt", bus.match_cnt, 32'(base + 1));

    // 5: reset mid-handshake with a pending hit
    sym_str("abcdabcd");
    chk("t5_found", bus.found, 1'b1);
    chk("t5_cnt_m", bus.match_cnt, 32'(m_cnt));
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_found", bus.found, 1'b0);
    chk("t5_async_cnt", bus.match_cnt, 8'd0);
    m_reset();
    #3;
    reset_n = 1'b1;
    ack_cycle("t5a", f);
    chk("t5_nothing_a", f, 1'b0);
    ack_cycle("t5b", f);
    chk("t5_nothing_b", f, 1'b0);

    // 6: idle gaps tolerated, foreign symbol breaks the match
    sym(CH_B);
    repeat (2) tick();
    sym(CH_O);
    tick();
    sym(CH_A);
    repeat (3) tick();
    sym(CH_B);
    chk("t6_gap_hit", bus.found, 1'b1);
    chk("t6_gap_cnt", bus.match_cnt, 8'd1);
    ack_cycle("t6", f);
    sym(CH_B); sym(CH_O); sym(CH_X); sym(CH_A); sym(CH_B);
    chk("t6_x_nohit", bus.found, 1'b0);
    chk("t6_x_cnt", bus.match_cnt, 8'd1);

    // overflow set and clear in the same cycle: set wins
    sym_str("boabboabboab");
    chk("ovf_set", bus.overflow, 1'b1);
    sym_str("boa");
    bus.ovf_clr = 1'b1;
    sym(CH_B);
    bus.ovf_clr = 1'b0;
    chk("ovf_set_wins", bus.overflow, 1'b1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", bus.overflow, 1'b0);
    ack_cycle("drain_a", f);
    ack_cycle("drain_b", f);
    chk("drain_idle", f, 1'b0);

    // randomized stream against the history model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 6))
        0, 1:    rsym = CH_B;
        2, 3:    rsym = CH_O;
        4, 5:    rsym = CH_A;
        default: rsym = CH_X;
      endcase
      bus.ack = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        sym(rsym);
      end else begin
        tick();
      end
      chk("rand_cnt", bus.match_cnt, 32'(m_cnt));
    end
    bus.ack = 1'b0;

    // counter saturation
    repeat (260) sym_str("boab");
    chk("sat_cnt", bus.match_cnt, 8'd255);
    chk("sat_cnt_m", bus.match_cnt, 32'(m_cnt));
    sym_str("boab");
    chk("sat_hold", bus.match_cnt, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
